// File: rtl/axis_vid_out_framer_if.sv
// AXI4-Stream bundle shared by the framer's upstream pixel port and its video output port.
interface axis_vid_out_framer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tuser;
    logic                  tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    // The upstream side carries no start-of-frame marker.
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_vid_out_framer.sv
// Re-frames the upscaler pixel stream as AXI4-Stream video (tuser = start of frame,
// tlast = end of line) behind a registered output/skid pair, checking upstream tlast.
module axis_vid_out_framer #(
    parameter int DATA_WIDTH     = 24,
    parameter int DST_IMG_WIDTH  = 3840,
    parameter int DST_IMG_HEIGHT = 2160,
    parameter int COL_W          = $clog2(DST_IMG_WIDTH),
    parameter int ROW_W          = $clog2(DST_IMG_HEIGHT) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr_err,
    axis_vid_out_framer_if.slave  s_axis,
    axis_vid_out_framer_if.master m_axis,
    output logic                  frame_done,
    output logic                  err_tlast
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(DST_IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } beat_t;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    beat_t            out_q, out_d, skd_q, skd_d, in_beat;
    logic             out_vld_q, out_vld_d;
    logic             skd_vld_q, skd_vld_d;
    logic             rdy_q, rdy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             acc, out_xfer, at_eol, at_eof, early_last;

    always_comb begin
        acc        = s_axis.tvalid & rdy_q;
        out_xfer   = out_vld_q & m_axis.tready;
        at_eol     = (col_q == COL_LAST);
        at_eof     = at_eol && (row_q == ROW_LAST);
        early_last = s_axis.tlast & ~at_eof;

        // An upstream tlast always closes the line and the frame on the output side.
        in_beat.data = s_axis.tdata;
        in_beat.sof  = (col_q == '0) && (row_q == '0);
        in_beat.eol  = at_eol | s_axis.tlast;
        in_beat.eof  = at_eof | s_axis.tlast;

        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (early_last) begin
                col_d = '0;
                row_d = '0;
            end else if (at_eol) begin
                col_d = '0;
                row_d = at_eof ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        out_d     = out_q;
        out_vld_d = out_vld_q;
        skd_d     = skd_q;
        skd_vld_d = skd_vld_q;
        // A full skid slot implies ready was low, so no accept can collide with the refill.
        if (skd_vld_q) begin
            if (out_xfer) begin
                out_d     = skd_q;
                skd_vld_d = 1'b0;
            end
        end else if (acc) begin
            if (!out_vld_q || out_xfer) begin
                out_d     = in_beat;
                out_vld_d = 1'b1;
            end else begin
                skd_d     = in_beat;
                skd_vld_d = 1'b1;
            end
        end else if (out_xfer) begin
            out_vld_d = 1'b0;
        end

        rdy_d  = enable & ~skd_vld_d;
        done_d = out_xfer & out_q.eof;
        err_d  = (acc && (s_axis.tlast != at_eof)) ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            out_q     <= '0;
            skd_q     <= '0;
            out_vld_q <= 1'b0;
            skd_vld_q <= 1'b0;
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            out_q     <= out_d;
            skd_q     <= skd_d;
            out_vld_q <= out_vld_d;
            skd_vld_q <= skd_vld_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign s_axis.tready = rdy_q;
    assign m_axis.tvalid = out_vld_q;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tuser  = out_q.sof;
    assign m_axis.tlast  = out_q.eol;
    assign frame_done    = done_q;
    assign err_tlast     = err_q;
endmodule
